// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the pong VGA path: default 640x480@60 Hz timing,
// the coordinate type used by the timing generator and renderer, and the
// bit positions of the VGA PMOD signals inside the uo_out byte.
// No ports (package).
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // uo_out layout of the TinyVGA PMOD
  localparam int PMOD_R1    = 0;
  localparam int PMOD_G1    = 1;
  localparam int PMOD_B1    = 2;
  localparam int PMOD_VSYNC = 3;
  localparam int PMOD_R0    = 4;
  localparam int PMOD_G0    = 5;
  localparam int PMOD_B0    = 6;
  localparam int PMOD_HSYNC = 7;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each step,
// wrapping to 0 after TOTAL-1. Decodes sync and active windows from the
// current count (combinational; the parent registers them).
// Ports:
//   clk    in  clock
//   clear  in  synchronous clear to 0 (has priority over step)
//   step   in  advance by one position
//   count  out current position
//   wrap   out count is at the last position of the axis
//   sync_n out low while count is inside the sync window
//   active out count is inside the visible region
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic   clk,
  input  logic   clear,
  input  logic   step,
  output coord_t count,
  output logic   wrap,
  output logic   sync_n,
  output logic   active
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  assign wrap   = (count == coord_t'(TOTAL - 1));
  assign sync_n = !((count >= coord_t'(SYNC_START)) && (count < coord_t'(SYNC_END)));
  assign active = (count < coord_t'(ACTIVE));

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running VGA raster timing generator. Two axis counters walk the
// raster; every output is registered from the counter values before the
// edge, so outputs lag the counters by one enabled cycle.
// Optional feature: define FRAME_CNT_EN to add the 8-bit frame_cnt output.
// Ports:
//   clk         in  pixel clock
//   rst_n       in  synchronous active-low reset
//   ena         in  advance enable; when low, everything holds, pulses go 0
//   hsync       out horizontal sync, active-low
//   vsync       out vertical sync, active-low
//   de          out display enable
//   x, y        out pixel coordinates, 0 outside the visible area
//   line_start  out pulse at h=0
//   frame_start out pulse at (0,0)
//   frame_end   out pulse at (H_ACTIVE, V_ACTIVE-1), game-update slot
//   frame_cnt   out completed-frame count (FRAME_CNT_EN only)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       frame_end
`ifdef FRAME_CNT_EN
  ,output logic [7:0] frame_cnt
`endif
);

  coord_t h, v;
  logic   h_wrap, h_sync_n, h_active;
  logic   v_wrap, v_sync_n, v_active;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk   (clk),
    .clear (!rst_n),
    .step  (ena),
    .count (h),
    .wrap  (h_wrap),
    .sync_n(h_sync_n),
    .active(h_active)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk   (clk),
    .clear (!rst_n),
    .step  (ena && h_wrap),
    .count (v),
    .wrap  (v_wrap),
    .sync_n(v_sync_n),
    .active(v_active)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else if (ena) begin
      hsync       <= h_sync_n;
      vsync       <= v_sync_n;
      de          <= h_active && v_active;
      x           <= h_active ? h : '0;
      y           <= v_active ? v : '0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      frame_end   <= (h == coord_t'(H_ACTIVE)) && (v == coord_t'(V_ACTIVE - 1));
    end else begin
      // levels hold; strobes must never repeat while stalled
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end
  end

`ifdef FRAME_CNT_EN
  // Counts on the raster wrap itself, so it is stable by the time the next
  // frame_start is visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (ena && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Two instances share stimulus: one with the
// default 640x480 timing, one with a tiny raster so whole frames (and the
// frame counter wrap) fit in a short run. Expected outputs come from the
// raster position p = (enabled edges since reset) - 1, decoded arithmetically.
module tb_vga_timing_gen;

  localparam int SHA = 8, SHF = 2, SHS = 2, SHB = 2;   // 14 per line
  localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 2;   // 8 lines
  localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  logic       s_hsync, s_vsync, s_de, s_ls, s_fs, s_fe;
  logic [9:0] s_x, s_y;
  logic       d_hsync, d_vsync, d_de, d_ls, d_fs, d_fe;
  logic [9:0] d_x, d_y;
`ifdef FRAME_CNT_EN
  logic [7:0] s_fcnt, d_fcnt;
`endif

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .frame_end(s_fe)
`ifdef FRAME_CNT_EN
    , .frame_cnt(s_fcnt)
`endif
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .frame_end(d_fe)
`ifdef FRAME_CNT_EN
    , .frame_cnt(d_fcnt)
`endif
  );

  typedef struct {
    logic hs, vs, de, ls, fs, fe;
    int   x, y;
  } exp_t;

  function automatic exp_t rst_val();
    exp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
    e.ls = 1'b0; e.fs = 1'b0; e.fe = 1'b0;
    e.x = 0; e.y = 0;
    return e;
  endfunction

  function automatic exp_t decode(int p, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb);
    exp_t e;
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int h = p % ht;
    int v = (p / ht) % vt;
    e.hs = !(h >= ha + hf && h < ha + hf + hs);
    e.vs = !(v >= va + vf && v < va + vf + vs);
    e.de = (h < ha) && (v < va);
    e.x  = (h < ha) ? h : 0;
    e.y  = (v < va) ? v : 0;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.fe = (h == ha) && (v == va - 1);
    return e;
  endfunction

  int   pos = 0;
  exp_t es = rst_val();
  exp_t ed = rst_val();

  always @(posedge clk) begin
    if (!rst_n) begin
      es = rst_val();
      ed = rst_val();
      pos = 0;
    end else if (ena) begin
      es = decode(pos, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
      ed = decode(pos, 640, 16, 96, 48, 480, 10, 2, 33);
      pos = pos + 1;
    end else begin
      es.ls = 1'b0; es.fs = 1'b0; es.fe = 1'b0;
      ed.ls = 1'b0; ed.fs = 1'b0; ed.fe = 1'b0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d (pos %0d, t=%0t)", tag, obs, expv, pos, $time);
    end
  endtask

  task automatic check_all();
    check("s_hsync", 32'(s_hsync), 32'(es.hs));
    check("s_vsync", 32'(s_vsync), 32'(es.vs));
    check("s_de",    32'(s_de),    32'(es.de));
    check("s_x",     32'(s_x),     32'(es.x));
    check("s_y",     32'(s_y),     32'(es.y));
    check("s_line_start",  32'(s_ls), 32'(es.ls));
    check("s_frame_start", 32'(s_fs), 32'(es.fs));
    check("s_frame_end",   32'(s_fe), 32'(es.fe));
    check("d_hsync", 32'(d_hsync), 32'(ed.hs));
    check("d_vsync", 32'(d_vsync), 32'(ed.vs));
    check("d_de",    32'(d_de),    32'(ed.de));
    check("d_x",     32'(d_x),     32'(ed.x));
    check("d_y",     32'(d_y),     32'(ed.y));
    check("d_line_start",  32'(d_ls), 32'(ed.ls));
    check("d_frame_start", 32'(d_fs), 32'(ed.fs));
    check("d_frame_end",   32'(d_fe), 32'(ed.fe));
`ifdef FRAME_CNT_EN
    if (!rst_n || pos == 0) begin
      check("s_frame_cnt_rst", 32'(s_fcnt), 32'd0);
      check("d_frame_cnt_rst", 32'(d_fcnt), 32'd0);
    end else if (es.fs) begin
      check("s_frame_cnt", 32'(s_fcnt), 32'(((pos - 1) / S_FRAME) % 256));
    end
    if (rst_n && ed.fs)
      check("d_frame_cnt", 32'(d_fcnt), 32'(((pos - 1) / 420000) % 256));
`endif
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    ena   = 1'b1;
    repeat (5) step();

    // free run: covers first lines of the full raster and many small frames
    rst_n = 1'b1;
    repeat (1700) step();

    // stall at x=100 on the full raster, then resume
    guard = 0;
    while (!(ed.de && ed.x == 100) && guard < 1000) begin
      step();
      guard++;
    end
    check("stall_point_found", 32'(guard < 1000), 32'd1);
    ena = 1'b0;
    repeat (10) step();
    ena = 1'b1;
    repeat (5) step();

    // random enable gaps and occasional mid-frame resets
    for (int i = 0; i < 6000; i++) begin
      ena   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    // clean run long enough for the small raster's frame counter to wrap
    rst_n = 1'b0;
    ena   = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (260 * S_FRAME + 20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
